// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor.
// A single full-adder cell plus a carry flip-flop processes the latched
// operands LSB-first, one bit per clock. Subtraction is done as
// a + ~b + 1. A one-cycle done pulse marks completion, and sum, cout and
// ovf are updated together on that completion edge.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    // Counter value while the MSB is being processed (the final RUN edge).
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    // Counter value while the bit just below the MSB is being processed.
    // The carry out of that bit is the carry into the MSB.
    localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             launch_s;
    logic             run_s;
    logic             last_s;
    logic             bit_s;
    logic             c_s;
    logic [WIDTH-1:0] res_nxt_s;

    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic             cmsb_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    // Majority of three inputs: the carry out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        maj3 = (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder cell and the result register contents after this bit.
    always_comb begin
        bit_s     = opa_r[0] ^ opb_r[0] ^ carry_r;
        c_s       = maj3(opa_r[0], opb_r[0], carry_r);
        res_nxt_s = {bit_s, res_r[WIDTH-1:1]};
        last_s    = (cnt_r == LAST_BIT);
        run_s     = (state_r == ST_RUN);
    end

    // Next-state logic. A launch happens only when start is sampled in IDLE or DONE.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                launch_s    = 1'b0;
            end
        endcase
    end

    // State register. busy and done are registered from the next state,
    // so each one matches its state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand shift registers, carry FF, carry-into-MSB FF and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cmsb_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (launch_s) begin
            opa_r   <= a;
            opb_r   <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= {CW{1'b0}};
        end else if (run_s) begin
            opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
            opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
            res_r   <= res_nxt_s;
            carry_r <= c_s;
            cnt_r   <= cnt_r + CW'(1);
            if (cnt_r == MSB_M1) begin
                cmsb_r <= c_s;
            end else begin
                cmsb_r <= cmsb_r;
            end
        end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            res_r   <= res_r;
            carry_r <= carry_r;
            cmsb_r  <= cmsb_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result outputs. They are updated only on the completion edge and
    // hold the last result otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (run_s && last_s) begin
            sum_r  <= res_nxt_s;
            cout_r <= c_s;
            ovf_r  <= cmsb_r ^ c_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=3 instance is swept
// exhaustively in add mode, and a WIDTH=8 instance runs directed add/sub,
// back-to-back, ignored-start, operand-hold and reset-abort cases.
module tb_serial_adder;

    logic       clk;
    int         total;
    int         bad;

    // WIDTH=3 instance signals
    logic       rst3, start3, sub3, cin3;
    logic [2:0] a3, b3, sum3;
    logic       busy3, done3, cout3, ovf3;

    // WIDTH=8 instance signals
    logic       rst8, start8, sub8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8, ovf8;

    // expected {cout, ovf, sum}
    logic [4:0] q3[$];
    logic [9:0] q8[$];
    logic [9:0] prev8;

    serial_adder #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst3), .start(start3), .sub(sub3), .a(a3), .b(b3),
        .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor for the WIDTH=3 instance
    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            chk("busy_with_done3", {31'd0, busy3}, 32'd0);
            if (q3.size() == 0) begin
                chk("extra_done3", {31'd0, done3}, 32'd0);
            end else begin
                chk("result3", {27'd0, cout3, ovf3, sum3}, {27'd0, q3.pop_front()});
            end
        end
    end

    // Monitor for the WIDTH=8 instance
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            chk("busy_with_done8", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                chk("extra_done8", {31'd0, done8}, 32'd0);
            end else begin
                chk("result8", {22'd0, cout8, ovf8, sum8}, {22'd0, q8.pop_front()});
            end
        end
    end

    // One WIDTH=3 add: latency and busy length are checked here, the result by the monitor.
    task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tci);
        logic [3:0] tot;
        logic       ov;
        int         bc;
        int         lat;
        bit         seen;
        tot = {1'b0, ta} + {1'b0, tb} + {3'd0, tci};
        ov  = (ta[2] == tb[2]) && (tot[2] != ta[2]);
        @(posedge clk); #1;
        a3 = ta; b3 = tb; cin3 = tci; sub3 = 1'b0; start3 = 1'b1;
        q3.push_back({tot[3], ov, tot[2:0]});
        @(posedge clk); #1;
        start3 = 1'b0; a3 = ~ta; b3 = ~tb; cin3 = ~tci;
        bc = 0; lat = -1; seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (done3) begin
                seen = 1'b1;
                lat  = i;
            end else if (busy3) begin
                bc++;
            end
        end
        chk("done3_seen", {31'd0, seen}, 32'd1);
        chk("latency3", lat, 32'd3);
        chk("busy_len3", bc, 32'd3);
    endtask

    // Waits for done8. Outputs must hold the previous result until then.
    task automatic wait_done8(input logic [9:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
            end else begin
                chk("hold8", {22'd0, cout8, ovf8, sum8}, {22'd0, prev8});
            end
        end
        chk("done8_seen", {31'd0, seen}, 32'd1);
        prev8 = exp;
    endtask

    // One WIDTH=8 op. The inputs are scrambled right after launch.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                       input logic tsub, input logic [9:0] exp);
        @(posedge clk); #1;
        a8 = ta; b8 = tb; cin8 = tci; sub8 = tsub; start8 = 1'b1;
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tci; sub8 = ~tsub;
        wait_done8(exp);
    endtask

    task automatic run3();
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op3(3'(ia), 3'(ib), 1'(ic));
                end
            end
        end
    endtask

    task automatic run8();
        // directed add / sub vectors, expected {cout, ovf, sum}
        op8(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
        op8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
        op8(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01});
        op8(8'h3C, 8'h5A, 1'b1, 1'b0, {1'b0, 1'b1, 8'h97});
        op8(8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE});
        op8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
        op8(8'h07, 8'h07, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00});
        op8(8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0});

        // back-to-back: start held high through RUN and DONE
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back({1'b0, 1'b0, 8'h46});
        @(posedge clk); #1;
        a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; sub8 = 1'b1;
        q8.push_back({1'b1, 1'b1, 8'h64});
        wait_done8({1'b0, 1'b0, 8'h46});
        @(posedge clk); #1;
        chk("b2b_no_bubble", {31'd0, busy8}, 32'd1);
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait_done8({1'b1, 1'b1, 8'h64});

        // start pulsed mid-RUN is ignored
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back({1'b1, 1'b0, 8'h00});
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; sub8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8({1'b1, 1'b0, 8'h00});
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_extra_done8", {31'd0, done8}, 32'd0);
        end

        // asynchronous reset in the middle of bit 4
        @(posedge clk); #1;
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst8 = 1'b1;
        #1;
        chk("rst_sum8", {24'd0, sum8}, 32'd0);
        chk("rst_cout8", {31'd0, cout8}, 32'd0);
        chk("rst_ovf8", {31'd0, ovf8}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        prev8 = 10'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_done8", {31'd0, done8}, 32'd0);
            chk("post_rst_busy8", {31'd0, busy8}, 32'd0);
        end
        op8(8'h01, 8'h02, 1'b0, 1'b0, {1'b0, 1'b0, 8'h03});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        total = 0; bad = 0; prev8 = 10'd0;
        rst3 = 1'b1; start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = 3'd0; b3 = 3'd0;
        rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        #12;
        chk("reset_sum8", {24'd0, sum8}, 32'd0);
        chk("reset_flags8", {28'd0, busy8, done8, cout8, ovf8}, 32'd0);
        chk("reset_sum3", {29'd0, sum3}, 32'd0);
        chk("reset_flags3", {28'd0, busy3, done3, cout3, ovf3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0; rst8 = 1'b0;
        fork
            run3();
            run8();
        join
        repeat (4) @(negedge clk);
        chk("q3_drained", q3.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
